// File: rtl/riscv_wb_arb.sv
// Writeback arbiter: buffers completed results per functional unit and drains
// them round-robin onto the register-file write ports, never writing one rd twice per cycle.

package riscv_pkg;
  localparam int REGISTER_PORTS = 2;
endpackage

module riscv_wb_arb #(
  parameter int SOURCES = 4,
  parameter int PORTS   = riscv_pkg::REGISTER_PORTS,
  parameter int DEPTH   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [SOURCES-1:0]       src_valid,
  input  logic [SOURCES-1:0][4:0]  src_rd,
  input  logic [SOURCES-1:0][31:0] src_data,
  output logic [SOURCES-1:0]       src_ready,
  output logic [PORTS-1:0]         register_write_en,
  output logic [PORTS-1:0][4:0]    register_write,
  output logic [PORTS-1:0][31:0]   register_write_data,
  output logic                     wb_idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  logic [4:0]                  r_memRd   [SOURCES][DEPTH];
  logic [31:0]                 r_memData [SOURCES][DEPTH];
  logic [SOURCES-1:0][AW-1:0]  r_wrPtr;
  logic [SOURCES-1:0][AW-1:0]  r_rdPtr;
  logic [SOURCES-1:0][CW-1:0]  r_count;
  logic [SW-1:0]               r_rrPtr;

  logic [SOURCES-1:0]          w_push;
  logic [SOURCES-1:0]          w_pop;
  logic [SOURCES-1:0][CW-1:0]  w_countNext;
  logic [PORTS-1:0]            w_grantEn;
  logic [PORTS-1:0][4:0]       w_grantRd;
  logic [PORTS-1:0][31:0]      w_grantData;
  logic                        w_anyGrant;
  logic [SW-1:0]               w_lastIdx;
  logic [SW-1:0]               w_rrNext;
  logic                        w_allEmptyNext;

  // Ready looks only at the registered count, so a full FIFO stays closed even if it pops this cycle.
  always_comb begin
    src_ready = '0;
    w_push    = '0;
    for (int n = 0; n < SOURCES; n++) begin
      src_ready[n] = (r_count[n] < CW'(DEPTH)) && !reset;
      w_push[n]    = src_valid[n] && src_ready[n];
    end
  end

  always_comb begin : arbitrate
    int            used;
    logic          conflict;
    logic [SW-1:0] idx;
    logic [4:0]    headRd;
    logic [31:0]   headData;
    used        = 0;
    conflict    = 1'b0;
    idx         = '0;
    headRd      = '0;
    headData    = '0;
    w_pop       = '0;
    w_grantEn   = '0;
    w_grantRd   = '0;
    w_grantData = '0;
    w_anyGrant  = 1'b0;
    w_lastIdx   = '0;
    for (int k = 0; k < SOURCES; k++) begin
      idx      = SW'((int'(r_rrPtr) + k) % SOURCES);
      headRd   = r_memRd[idx][r_rdPtr[idx]];
      headData = r_memData[idx][r_rdPtr[idx]];
      conflict = 1'b0;
      if (r_count[idx] != '0) begin
        // x0 writes are architecturally discarded, so they drain without using a port.
        if (headRd == 5'd0) begin
          w_pop[idx] = 1'b1;
        end else if (used < PORTS) begin
          for (int p = 0; p < PORTS; p++) begin
            if (w_grantEn[p] && (w_grantRd[p] == headRd)) conflict = 1'b1;
          end
          if (!conflict) begin
            for (int p = 0; p < PORTS; p++) begin
              if (p == used) begin
                w_grantEn[p]   = 1'b1;
                w_grantRd[p]   = headRd;
                w_grantData[p] = headData;
              end
            end
            used       = used + 1;
            w_pop[idx] = 1'b1;
            w_lastIdx  = idx;
            w_anyGrant = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_allEmptyNext = 1'b1;
    w_countNext    = '0;
    for (int n = 0; n < SOURCES; n++) begin
      w_countNext[n] = r_count[n] + CW'(w_push[n]) - CW'(w_pop[n]);
      if (w_countNext[n] != '0) w_allEmptyNext = 1'b0;
    end
    w_rrNext = (w_lastIdx == SW'(SOURCES - 1)) ? '0 : w_lastIdx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr             <= '0;
      r_rdPtr             <= '0;
      r_count             <= '0;
      r_rrPtr             <= '0;
      register_write_en   <= '0;
      register_write      <= '0;
      register_write_data <= '0;
      wb_idle             <= 1'b1;
    end else begin
      for (int n = 0; n < SOURCES; n++) begin
        if (w_push[n]) begin
          r_memRd[n][r_wrPtr[n]]   <= src_rd[n];
          r_memData[n][r_wrPtr[n]] <= src_data[n];
          r_wrPtr[n]               <= r_wrPtr[n] + 1'b1;
        end
        if (w_pop[n]) r_rdPtr[n] <= r_rdPtr[n] + 1'b1;
        r_count[n] <= w_countNext[n];
      end
      if (w_anyGrant) r_rrPtr <= w_rrNext;
      // Ungranted ports keep their last rd/data; only the strobe drops.
      for (int p = 0; p < PORTS; p++) begin
        register_write_en[p] <= w_grantEn[p];
        if (w_grantEn[p]) begin
          register_write[p]      <= w_grantRd[p];
          register_write_data[p] <= w_grantData[p];
        end
      end
      wb_idle <= w_allEmptyNext && !(|w_grantEn);
    end
  end

endmodule

// File: tb/tb_riscv_wb_arb.sv
// Directed bench for riscv_wb_arb: stimulus queues expected port writes, a
// negedge monitor pops and compares every write the arbiter emits.

module tb_riscv_wb_arb;

  localparam int SOURCES = 4;
  localparam int PORTS   = 2;
  localparam int DEPTH   = 2;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic [SOURCES-1:0]       src_valid = '0;
  logic [SOURCES-1:0][4:0]  src_rd = '0;
  logic [SOURCES-1:0][31:0] src_data = '0;
  logic [SOURCES-1:0]       src_ready;
  logic [PORTS-1:0]         register_write_en;
  logic [PORTS-1:0][4:0]    register_write;
  logic [PORTS-1:0][31:0]   register_write_data;
  logic                     wb_idle;

  typedef struct {
    int          port;
    logic [4:0]  rd;
    logic [31:0] data;
  } expWrite_t;

  expWrite_t sbQ[$];
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  riscv_wb_arb #(.SOURCES(SOURCES), .PORTS(PORTS), .DEPTH(DEPTH)) dut (
    .clock               (clock),
    .reset               (reset),
    .src_valid           (src_valid),
    .src_rd              (src_rd),
    .src_data            (src_data),
    .src_ready           (src_ready),
    .register_write_en   (register_write_en),
    .register_write      (register_write),
    .register_write_data (register_write_data),
    .wb_idle             (wb_idle)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input int port, input logic [4:0] rd, input logic [31:0] data);
    expWrite_t e;
    e.port = port;
    e.rd   = rd;
    e.data = data;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input int n, input logic [4:0] rd, input logic [31:0] data);
    src_valid[n] = 1'b1;
    src_rd[n]    = rd;
    src_data[n]  = data;
  endtask

  task automatic applyStimulus();
    tick();
    src_valid = '0;
  endtask

  task automatic resetDut(input string tag);
    reset     = 1'b1;
    src_valid = '0;
    tick();
    checkOutput({tag, "_ready_in_reset"}, 32'(src_ready), 32'h0);
    reset = 1'b0;
    #1;
    checkOutput({tag, "_ready_after_reset"}, 32'(src_ready), 32'hF);
    checkOutput({tag, "_en_after_reset"}, 32'(register_write_en), 32'h0);
    checkOutput({tag, "_idle_after_reset"}, 32'(wb_idle), 32'h1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sbQ.size() != 0 || register_write_en != '0) && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_sb_empty"}, 32'(sbQ.size()), 32'h0);
  endtask

  // Monitor: every asserted strobe must match the next queued write, and no two ports may share an rd.
  always @(negedge clock) begin
    for (int p = 0; p < PORTS; p++) begin
      for (int q = p + 1; q < PORTS; q++) begin
        if (register_write_en[p] && register_write_en[q])
          checkOutput("dup_rd_same_cycle", 32'(register_write[p] == register_write[q]), 32'h0);
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      if (register_write_en[p]) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: port %0d rd %0d data 0x%0h, expected no write",
                   p, register_write[p], register_write_data[p]);
        end else begin
          expWrite_t e;
          e = sbQ.pop_front();
          checkOutput("sb_port", 32'(p), 32'(e.port));
          checkOutput("sb_rd", 32'(register_write[p]), 32'(e.rd));
          checkOutput("sb_data", register_write_data[p], e.data);
        end
      end
    end
  end

  initial begin
    logic [4:0] rd0Tbl [6];
    logic       rdy0Tbl [6];
    rd0Tbl  = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd11, 5'd12};
    rdy0Tbl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    resetDut("init");
    checkOutput("init_write0", 32'(register_write[0]), 32'h0);
    checkOutput("init_data1", register_write_data[1], 32'h0);

    // Single result: one-cycle latency onto port 0, then idle again.
    expectWrite(0, 5'd5, 32'hDEADBEEF);
    offer(0, 5'd5, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("t1_en_k", 32'(register_write_en), 32'h0);
    checkOutput("t1_idle_k", 32'(wb_idle), 32'h0);
    tick();
    checkOutput("t1_en_k1", 32'(register_write_en), 32'h1);
    checkOutput("t1_rd_k1", 32'(register_write[0]), 32'd5);
    checkOutput("t1_idle_k1", 32'(wb_idle), 32'h0);
    tick();
    checkOutput("t1_en_k2", 32'(register_write_en), 32'h0);
    checkOutput("t1_idle_k2", 32'(wb_idle), 32'h1);
    drain("t1");

    // Port saturation: sources 0,1 first, then 2,3; pointer wraps back to 0.
    resetDut("t2");
    for (int n = 0; n < SOURCES; n++) begin
      offer(n, 5'(n + 1), 32'hA0 + 32'(n + 1));
      expectWrite(n % 2, 5'(n + 1), 32'hA0 + 32'(n + 1));
    end
    applyStimulus();
    tick();
    checkOutput("t2_en_c1", 32'(register_write_en), 32'h3);
    checkOutput("t2_rd0_c1", 32'(register_write[0]), 32'd1);
    tick();
    checkOutput("t2_en_c2", 32'(register_write_en), 32'h3);
    checkOutput("t2_rd1_c2", 32'(register_write[1]), 32'd4);
    expectWrite(0, 5'd5, 32'hB5);
    expectWrite(1, 5'd6, 32'hB6);
    offer(0, 5'd5, 32'hB5);
    offer(3, 5'd6, 32'hB6);
    applyStimulus();
    tick();
    checkOutput("t2_rd1_wrap", 32'(register_write[1]), 32'd6);
    drain("t2");

    // Same rd from two sources: serialised over two cycles.
    resetDut("t3");
    expectWrite(0, 5'd7, 32'h11);
    expectWrite(0, 5'd7, 32'h22);
    offer(0, 5'd7, 32'h11);
    offer(1, 5'd7, 32'h22);
    applyStimulus();
    tick();
    checkOutput("t3_en_c1", 32'(register_write_en), 32'h1);
    checkOutput("t3_data_c1", register_write_data[0], 32'h11);
    tick();
    checkOutput("t3_en_c2", 32'(register_write_en), 32'h1);
    checkOutput("t3_data_c2", register_write_data[0], 32'h22);
    drain("t3");

    // x0 entry drains without a port while rd 3 and 4 share the cycle.
    resetDut("t4");
    expectWrite(0, 5'd3, 32'h33);
    expectWrite(1, 5'd4, 32'h44);
    offer(0, 5'd3, 32'h33);
    offer(1, 5'd4, 32'h44);
    offer(2, 5'd0, 32'h99);
    applyStimulus();
    tick();
    checkOutput("t4_en_c1", 32'(register_write_en), 32'h3);
    tick();
    checkOutput("t4_en_c2", 32'(register_write_en), 32'h0);
    checkOutput("t4_idle_c2", 32'(wb_idle), 32'h1);
    drain("t4");

    // Backpressure: source 0 offers every cycle while sources 1-3 compete for ports.
    resetDut("t5");
    expectWrite(0, 5'd8,  32'h5000_0008);
    expectWrite(1, 5'd14, 32'h5000_000E);
    expectWrite(0, 5'd16, 32'h5000_0010);
    expectWrite(1, 5'd18, 32'h5000_0012);
    expectWrite(0, 5'd9,  32'h5000_0009);
    expectWrite(1, 5'd15, 32'h5000_000F);
    expectWrite(0, 5'd17, 32'h5000_0011);
    expectWrite(1, 5'd19, 32'h5000_0013);
    expectWrite(0, 5'd10, 32'h5000_000A);
    expectWrite(0, 5'd11, 32'h5000_000B);
    for (int i = 0; i < 6; i++) begin
      offer(0, rd0Tbl[i], 32'h5000_0000 | 32'(rd0Tbl[i]));
      if (i < 2) begin
        for (int n = 1; n < SOURCES; n++)
          offer(n, 5'(12 + 2 * n + i), 32'h5000_0000 | 32'(12 + 2 * n + i));
      end
      checkOutput($sformatf("t5_ready0_c%0d", i), 32'(src_ready[0]), 32'(rdy0Tbl[i]));
      applyStimulus();
    end
    drain("t5");

    // Reset mid-operation: buffered entries vanish, writes already emitted stand.
    resetDut("t6");
    expectWrite(0, 5'd20, 32'h60);
    expectWrite(1, 5'd21, 32'h61);
    for (int n = 0; n < SOURCES; n++) offer(n, 5'(20 + n), 32'h60 + 32'(n));
    applyStimulus();
    for (int n = 0; n < SOURCES; n++) offer(n, 5'(24 + n), 32'h64 + 32'(n));
    applyStimulus();
    checkOutput("t6_en_before_reset", 32'(register_write_en), 32'h3);
    reset = 1'b1;
    #1;
    checkOutput("t6_ready_in_reset", 32'(src_ready), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t6_en_after", 32'(register_write_en), 32'h0);
    checkOutput("t6_idle_after", 32'(wb_idle), 32'h1);
    checkOutput("t6_ready_after", 32'(src_ready), 32'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t6_no_stale_c%0d", i), 32'(register_write_en), 32'h0);
    end
    checkOutput("t6_idle_end", 32'(wb_idle), 32'h1);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/riscv_wb_arb.md
Name: riscv_wb_arb

Overview:
- Writeback arbiter sitting directly upstream of the register file.
- Collects completed results (rd, data) from SOURCES functional units (ALU, load, mul/div, CSR) through valid/ready handshakes.
- Buffers each source in a small FIFO and round-robin drains up to PORTS results per cycle onto the register-file write ports.
- Guarantees no two ports write the same register in one cycle.

Parameters:
- SOURCES, 4, number of result-producing units.
- PORTS, riscv_pkg::REGISTER_PORTS, number of register-file write ports driven.
- DEPTH, 2, entries per source FIFO (power of 2, >=2).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- src_valid  input  [SOURCES-1:0]  source n presents a result.
- src_rd  input  [SOURCES-1:0][4:0]  destination register.
- src_data  input  [SOURCES-1:0][31:0]  result value.
- src_ready  output  [SOURCES-1:0]  source n FIFO can accept.
- register_write_en  output  [PORTS-1:0]  port write strobe (registered).
- register_write  output  [PORTS-1:0][4:0]  port destination (registered).
- register_write_data  output  [PORTS-1:0][31:0]  port data (registered).
- wb_idle  output  1  all FIFOs empty and no write_en asserted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - All FIFOs emptied (counts 0, pointers 0); rr_ptr=0.
  - register_write_en=0, register_write=0, register_write_data=0.
  - wb_idle=1.
  - src_ready forced 0 while reset is high.
- Handshake:
  - src_ready[n] = (count[n] < DEPTH) && !reset. It depends only on registered count, with no valid-to-ready combinational path.
  - Push occurs when src_valid[n] && src_ready[n] at a clock edge.
  - When full, a same-cycle pop does not raise ready that cycle.
  - Push and pop on the same FIFO in the same cycle is legal; count unchanged.
- Arbitration, combinational on FIFO heads each cycle:
  - Scan sources in order rr_ptr, rr_ptr+1, ... mod SOURCES.
  - Head with rd==0: popped, takes no port, and is not limited per cycle.
  - Head with rd!=0: granted the next free port (port index ascending in scan order) if a port is free and its rd differs from every rd already granted this cycle. Otherwise it waits.
  - Each source pops at most one entry per cycle.
- rr_ptr update:
  - rr_ptr <= (index of last source granted a port) + 1 mod SOURCES.
  - Unchanged if no port was granted. x0 drains do not move it.
- Output registers:
  - Granted port p at edge k: register_write_en[p]=1, register_write[p]=rd, register_write_data[p]=data, visible in the cycle after edge k.
  - Ungranted ports: write_en=0; register_write/register_write_data hold their previous value (don't-care).
- Latency: a result accepted at edge k appears on a write port after edge k+1 at the earliest (1 cycle of buffering). The register file then commits at edge k+2.
- Ordering:
  - Per-source FIFO order is preserved.
  - No ordering is guaranteed across sources. Issue logic keeps rd locked until writeback, so two in-flight writes to the same rd from different sources do not occur. The arbiter still never emits a duplicate rd in one cycle.
- Fairness: with all sources continuously non-empty and distinct rd, each source receives a grant at least once every ceil(SOURCES/PORTS) cycles.
- wb_idle is registered: 1 when all counts are 0 after the edge and no write_en is asserted.
- Reset mid-operation discards all buffered results and any pending write_en on the next edge; no write is emitted after reset rises.

Test Plan:
- Single result: src_valid[0]=1, rd=5, data=0xDEADBEEF for one cycle (edge k). Required: register_write_en[0]=1, register_write[0]=5, register_write_data[0]=0xDEADBEEF after edge k+1 for exactly one cycle, port 1 idle, wb_idle=0 then 1.
- Port saturation: all 4 sources push distinct rd 1..4 in the same cycle, PORTS=2. Required: sources 0,1 written first cycle, sources 2,3 next cycle, rr_ptr 0→2→0.
- Same-rd conflict: sources 0 and 1 both push rd=7 with data 0x11 and 0x22. Required: only 0x11 written in the first cycle, 0x22 written the following cycle, never both in one cycle.
- x0 drain: source 2 pushes rd=0 while sources 0,1 push rd=3,4. Required: x0 entry popped with no write_en, rd 3 and 4 written on ports 0,1 in the same cycle.
- Backpressure: hold src_valid[0]=1 with distinct rd for 6 cycles while sources 1-3 stay busy. Required: src_ready[0] drops after DEPTH=2 unpopped pushes, and no result is lost or duplicated (scoreboard of rd/data matches).
- Reset mid-operation: fill FIFOs, assert reset 1 cycle. Required: write_en=0 after that edge, src_ready=0 during reset and 1 after, no stale writes afterwards, wb_idle=1.
